otter_cu_fsm_mc: RTL

Parametrised multicycle control FSM for the OTTER core. It sequences fetch, execute, writeback and interrupt entry, with memory wait-states through a ready handshake. ENCRY instructions run for a programmable number of execute cycles. It sits between the instruction register/decoder and the PC, register file, memory, CSR and crypto-unit enables.

---
 rtl/otter_pkg.sv | 36 +++
 rtl/otter_cu_fsm_mc_crypt_counter.sv | 29 ++
 rtl/otter_cu_fsm_mc.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/otter_pkg.sv
// Shared OTTER definitions: opcodes, SYSTEM func3 codes, MRET encoding.
package otter_pkg;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_SYSTEM = 7'b1110011,
        OP_ENCRY  = 7'b0011100
    } opcode_t;

    typedef enum logic [2:0] {
        F3_TRAP  = 3'b000,
        F3_CSRRW = 3'b001,
        F3_CSRRS = 3'b010,
        F3_CSRRC = 3'b011
    } funct3_system_t;

    localparam logic [11:0] FUNC12_MRET = 12'h302;

    // True for every opcode the control unit knows how to sequence.
    function automatic logic op_legal(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_IMM, OP_REG, OP_SYSTEM, OP_ENCRY: op_legal = 1'b1;
            default:                                       op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/otter_cu_fsm_mc_crypt_counter.sv
// ENCRY execute-cycle counter: loaded on entry to CRYPT, cleared at its last cycle.
module cu_crypt_counter #(
    parameter int CRYPT_CYCLES = 4,
    parameter int CNT_W        = $clog2(CRYPT_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             advance,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CRYPT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    assign last = (count == LAST_IDX);

    // EXEC already used index 0, so CRYPT starts at 1 and wraps to 0 on exit.
    always_ff @(posedge clk) begin
        if (!resetn)
            count <= '0;
        else if (load)
            count <= ONE;
        else if (advance)
            count <= last ? '0 : count + ONE;
    end

endmodule

// File: rtl/otter_cu_fsm_mc.sv
// Multicycle OTTER control FSM: fetch, execute, ENCRY, writeback, interrupt entry.
module otter_cu_fsm_mc
    import otter_pkg::*;
#(
    parameter int CRYPT_CYCLES  = 4,
    parameter int CNT_W         = $clog2(CRYPT_CYCLES + 1),
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic             CU_CLK,
    input  logic             CU_RESETN,
    input  logic             CU_INT,
    input  logic             CU_prevINT,
    input  logic             CU_MEM_READY,
    input  logic [6:0]       CU_OPCODE,
    input  logic [2:0]       CU_FUNC3,
    input  logic [11:0]      CU_FUNC12,
    output logic             CU_PCWRITE,
    output logic             CU_REGWRITE,
    output logic             CU_MEMWRITE,
    output logic             CU_MEMREAD1,
    output logic             CU_MEMREAD2,
    output logic             CU_intTaken,
    output logic             CU_csrWrite,
    output logic             CU_intCLR,
    output logic             CU_ILLEGAL,
    output logic             crypto_start,
    output logic             crypto_busy,
    output logic [CNT_W-1:0] crypto_count
);

    typedef enum logic [2:0] {
        ST_FETCH, ST_EXEC, ST_CRYPT, ST_WB, ST_INTER
    } cu_state_t;

    localparam bit SINGLE_CRYPT = (CRYPT_CYCLES == 1);

    cu_state_t        state, next_state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last, cnt_load, cnt_adv;
    logic             ready, int_pend, complete;
    logic             is_load, is_store, is_encry, is_branch, is_system;
    logic             is_mret, is_legal, writes_rd;

    assign ready     = MEM_HANDSHAKE ? CU_MEM_READY : 1'b1;
    assign int_pend  = CU_INT | CU_prevINT;

    assign is_load   = (CU_OPCODE == OP_LOAD);
    assign is_store  = (CU_OPCODE == OP_STORE);
    assign is_encry  = (CU_OPCODE == OP_ENCRY);
    assign is_branch = (CU_OPCODE == OP_BRANCH);
    assign is_system = (CU_OPCODE == OP_SYSTEM);
    assign is_mret   = is_system && (CU_FUNC3 == F3_TRAP) && (CU_FUNC12 == FUNC12_MRET);
    assign is_legal  = op_legal(CU_OPCODE);
    assign writes_rd = is_legal && !is_branch && !is_store && !is_mret;

    // Counter is gated by reset through its own sync clear, so an abort leaves it at 0.
    assign cnt_load = CU_RESETN && (state == ST_EXEC) && is_encry && !SINGLE_CRYPT;
    assign cnt_adv  = CU_RESETN && (state == ST_CRYPT);

    cu_crypt_counter #(
        .CRYPT_CYCLES (CRYPT_CYCLES),
        .CNT_W        (CNT_W)
    ) u_crypt_counter (
        .clk     (CU_CLK),
        .resetn  (CU_RESETN),
        .load    (cnt_load),
        .advance (cnt_adv),
        .count   (cnt),
        .last    (cnt_last)
    );

    // Completion cycle: the one cycle per instruction that writes PC and may take an interrupt.
    always_comb begin
        complete = 1'b0;
        case (state)
            ST_EXEC: begin
                if (is_load)       complete = 1'b0;
                else if (is_store) complete = ready;
                else if (is_encry) complete = SINGLE_CRYPT;
                else               complete = 1'b1;
            end
            ST_CRYPT: complete = cnt_last;
            ST_WB:    complete = 1'b1;
            default:  complete = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge CU_CLK) begin
        if (!CU_RESETN)
            state <= ST_FETCH;
        else
            state <= next_state;
    end

    // Next-state logic; interrupts are only considered on completion cycles.
    always_comb begin
        next_state = state;
        case (state)
            ST_FETCH: if (ready) next_state = ST_EXEC;
            ST_EXEC: begin
                if (is_load) begin
                    if (ready) next_state = ST_WB;
                end else if (is_encry && !SINGLE_CRYPT) begin
                    next_state = ST_CRYPT;
                end else if (complete) begin
                    next_state = int_pend ? ST_INTER : ST_FETCH;
                end
            end
            ST_CRYPT: if (complete) next_state = int_pend ? ST_INTER : ST_FETCH;
            ST_WB:    next_state = int_pend ? ST_INTER : ST_FETCH;
            ST_INTER: next_state = ST_FETCH;
            default:  next_state = ST_FETCH;
        endcase
    end

    // Output decode; everything is held at 0 while reset is asserted.
    always_comb begin
        CU_PCWRITE   = 1'b0;
        CU_REGWRITE  = 1'b0;
        CU_MEMWRITE  = 1'b0;
        CU_MEMREAD1  = 1'b0;
        CU_MEMREAD2  = 1'b0;
        CU_intTaken  = 1'b0;
        CU_csrWrite  = 1'b0;
        CU_intCLR    = 1'b0;
        CU_ILLEGAL   = 1'b0;
        crypto_start = 1'b0;
        crypto_busy  = 1'b0;
        crypto_count = '0;
        if (CU_RESETN) begin
            crypto_count = cnt;
            CU_PCWRITE   = complete || (state == ST_INTER);
            CU_intCLR    = complete || (state == ST_INTER);
            CU_REGWRITE  = complete && writes_rd;
            case (state)
                ST_FETCH: CU_MEMREAD1 = 1'b1;
                ST_EXEC: begin
                    CU_MEMREAD2  = is_load;
                    CU_MEMWRITE  = is_store;
                    crypto_start = is_encry;
                    crypto_busy  = is_encry;
                    CU_ILLEGAL   = !is_legal;
                    CU_csrWrite  = is_system && (CU_FUNC3 == F3_CSRRW);
                end
                ST_CRYPT: crypto_busy = 1'b1;
                ST_INTER: CU_intTaken = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
